// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN
// is defined) feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_read,
    output logic [7:0] o_read_data,
    output logic       o_read_data_empty,
    output logic       o_rx_busy,
    output logic       o_frame_error,
    output logic       o_parity_error,
    output logic       o_overrun
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / (BAUD_RATE * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic             rx_meta, rx_sync;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [3:0]       sample_q;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q;
    logic             parity_bad_q, parity_bad_d;

    logic div_clr, sample_clr, shift_en, push, pop, full;
    logic frame_err_c, parity_err_c, overrun_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       head_d;

    assign tick = (div_q == DIV_W'(DIV - 1));
    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = i_read && (count_q != '0);

    // Receive FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Receive FSM next state and per-cycle control strobes
    always_comb begin
        state_d      = state_q;
        div_clr      = 1'b0;
        sample_clr   = 1'b0;
        shift_en     = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        parity_bad_d = parity_bad_q;
        push         = 1'b0;
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
        overrun_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sample_clr = 1'b1;
                if (!rx_sync) begin
                    state_d      = ST_START;
                    div_clr      = 1'b1;
                    bit_cnt_d    = 3'd0;
                    parity_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick && sample_q == 4'd7) begin
                    if (rx_sync) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        sample_clr = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick && sample_q == 4'd15) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick && sample_q == 4'd15) begin
                    if (rx_sync != ^shift_q) begin
                        parity_err_c = 1'b1;
                        parity_bad_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick && sample_q == 4'd15) begin
                    if (rx_sync) begin
                        if (!parity_bad_q) begin
                            if (full && !pop) overrun_c = 1'b1;
                            else              push      = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchronizer, baud/sample counters, shift register and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta        <= 1'b1;
            rx_sync        <= 1'b1;
            div_q          <= '0;
            sample_q       <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parity_bad_q   <= 1'b0;
            o_rx_busy      <= 1'b0;
            o_frame_error  <= 1'b0;
            o_parity_error <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            if (div_clr || tick) div_q <= '0;
            else                 div_q <= DIV_W'(div_q + DIV_W'(1));
            if (sample_clr) sample_q <= '0;
            else if (tick)  sample_q <= 4'(sample_q + 4'd1);
            bit_cnt_q    <= bit_cnt_d;
            parity_bad_q <= parity_bad_d;
            if (shift_en) shift_q <= {rx_sync, shift_q[7:1]};
            o_rx_busy      <= (state_d != ST_IDLE);
            o_frame_error  <= frame_err_c;
            o_parity_error <= parity_err_c;
            o_overrun      <= overrun_c;
        end
    end

    // FIFO pointer/occupancy update and next head word, honouring same-cycle push and pop
    always_comb begin
        rd_ptr_d = pop ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
        if (count_d == '0)                         head_d = o_read_data;
        else if (push && (wr_ptr_q == rd_ptr_d))   head_d = shift_q;
        else                                       head_d = mem[rd_ptr_d];
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= shift_q;
    end

    // FIFO control registers and registered head/empty outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            o_read_data       <= 8'h00;
            o_read_data_empty <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            o_read_data       <= head_d;
            o_read_data_empty <= (count_d == '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed serial frames with a read-data scoreboard and error-pulse counters.
module tb_uart_rx_fifo;

    localparam int BIT = 864;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_EDGE = 9074;
`else
    localparam int STOP_EDGE = 8210;
`endif

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_read = 1'b0;
    logic [7:0] o_read_data;
    logic       o_read_data_empty;
    logic       o_rx_busy;
    logic       o_frame_error;
    logic       o_parity_error;
    logic       o_overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_rx              (i_rx),
        .i_read            (i_read),
        .o_read_data       (o_read_data),
        .o_read_data_empty (o_read_data_empty),
        .o_rx_busy         (o_rx_busy),
        .o_frame_error     (o_frame_error),
        .o_parity_error    (o_parity_error),
        .o_overrun         (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted read and counts error pulses
    always begin
        logic [7:0] e;
        @(negedge clk);
        #1;
        if (!i_reset) begin
            if (i_read && !o_read_data_empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: got 0x%02h expected no data", o_read_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_read_data !== e) begin
                        errors++;
                        $display("FAIL read_data: got 0x%02h expected 0x%02h", o_read_data, e);
                    end
                end
            end
            if (o_frame_error)  fe_cnt++;
            if (o_parity_error) pe_cnt++;
            if (o_overrun)      ov_cnt++;
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "bench timed out");
    end

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop_v);
        i_rx = 1'b1;
    endtask

    task automatic read_one();
        i_read = 1'b1;
        @(negedge clk);
        i_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", 32'(o_read_data_empty), 32'd1);
        chk("rst_data", 32'(o_read_data), 32'h00);
        chk("rst_busy", 32'(o_rx_busy), 32'd0);
        chk("rst_fe", 32'(o_frame_error), 32'd0);
        chk("rst_pe", 32'(o_parity_error), 32'd0);
        chk("rst_ov", 32'(o_overrun), 32'd0);
        i_reset = 1'b0;
        repeat (20) @(negedge clk);

        // single good byte
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("aa_empty", 32'(o_read_data_empty), 32'd0);
        chk("aa_head", 32'(o_read_data), 32'hAA);
        read_one();
        chk("aa_empty_after_read", 32'(o_read_data_empty), 32'd1);
        chk("aa_busy_idle", 32'(o_rx_busy), 32'd0);

        // 300-cycle start glitch, also start-detect latency
        i_rx = 1'b0;
        repeat (2) @(negedge clk);
        chk("detect_busy_early", 32'(o_rx_busy), 32'd0);
        @(negedge clk);
        chk("detect_busy", 32'(o_rx_busy), 32'd1);
        repeat (297) @(negedge clk);
        i_rx = 1'b1;
        for (int i = 0; i < 140 && o_rx_busy; i++) @(negedge clk);
        chk("glitch_busy_clear", 32'(o_rx_busy), 32'd0);
        chk("glitch_empty", 32'(o_read_data_empty), 32'd1);
        chk("glitch_no_fe", 32'(fe_cnt), 32'd0);
        chk("glitch_no_ov", 32'(ov_cnt), 32'd0);
        repeat (20) @(negedge clk);

        // framing error with line held low
        send_frame(8'h55, 1'b0, 1'b0);
        i_rx = 1'b0;
        chk("break_busy_hold", 32'(o_rx_busy), 32'd1);
        chk("break_fe_cnt", 32'(fe_cnt), 32'd1);
        send_bit(1'b0);
        chk("break_still_busy", 32'(o_rx_busy), 32'd1);
        i_rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_release", 32'(o_rx_busy), 32'd0);
        chk("break_empty", 32'(o_read_data_empty), 32'd1);
        chk("break_fe_single", 32'(fe_cnt), 32'd1);
        repeat (20) @(negedge clk);

        exp_q.push_back(8'hCC);
        send_frame(8'hCC, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("cc_head", 32'(o_read_data), 32'hCC);
        read_one();
        chk("cc_empty_after_read", 32'(o_read_data_empty), 32'd1);

        // back-to-back burst into a 4-deep FIFO; fifth byte overruns
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hCC);
        exp_q.push_back(8'hDD);
        send_frame(8'hAA, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hCC, 1'b1, 1'b0);
        send_frame(8'hDD, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("burst_ov_cnt", 32'(ov_cnt), 32'd1);
        chk("burst_head", 32'(o_read_data), 32'hAA);

        // pop exactly in the stop-sample cycle of a full FIFO
        exp_q.push_back(8'h11);
        fork
            send_frame(8'h11, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE) @(posedge clk);
                @(negedge clk);
                i_read = 1'b1;
                @(negedge clk);
                i_read = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("pop_stop_no_ov", 32'(ov_cnt), 32'd1);
        chk("pop_stop_head", 32'(o_read_data), 32'h55);
        repeat (4) read_one();
        chk("drain_empty", 32'(o_read_data_empty), 32'd1);
        read_one();
        chk("empty_read_hold", 32'(o_read_data), 32'h11);

        // reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        i_reset = 1'b1;
        i_rx = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(o_rx_busy), 32'd0);
        chk("midrst_empty", 32'(o_read_data_empty), 32'd1);
        chk("midrst_data", 32'(o_read_data), 32'h00);
        repeat (20) @(negedge clk);
        exp_q.push_back(8'hDD);
        send_frame(8'hDD, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("dd_head", 32'(o_read_data), 32'hDD);
        read_one();
        chk("dd_empty_after_read", 32'(o_read_data_empty), 32'd1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'hDD, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("par_err_cnt", 32'(pe_cnt), 32'd1);
        chk("par_err_empty", 32'(o_read_data_empty), 32'd1);
        chk("par_err_no_fe", 32'(fe_cnt), 32'd1);
`else
        chk("no_parity_pulses", 32'(pe_cnt), 32'd0);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_ov_cnt", 32'(ov_cnt), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
